// File: rtl/word_unpacker.sv
// Word-to-byte unpacker: accepts a wide word with a byte count and emits its
// bytes LSB first on a valid/ready byte stream, allowing back-to-back words.
module word_unpacker #(
  parameter int width = 32,
  parameter int cntw  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  input  logic [cntw-1:0]  in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int nbytes = width / 8;
  localparam logic [cntw-1:0] nbytes_c = cntw'(nbytes);
  localparam logic [cntw-1:0] one_c    = cntw'(1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t           state, state_next;
  logic [width-1:0] word_q, word_next;
  logic [cntw-1:0]  index_q, index_next;
  logic [cntw-1:0]  count_q, count_next;
  logic [7:0]       data_q, data_next;
  logic             last_q, last_next;

  logic             accept;
  logic             transfer;
  logic [cntw-1:0]  count_eff;
  logic [cntw-1:0]  index_inc;
  logic [7:0]       byte_sel;

  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign out_data  = data_q;
  assign out_last  = last_q;

  // A new word may enter while the final byte of the current one leaves.
  assign in_ready  = !reset && ((state == IDLE) || (last_q && out_ready));
  assign accept    = in_valid && in_ready;
  assign transfer  = (state == SEND) && out_ready;
  assign index_inc = index_q + one_c;

  always_comb begin
    count_eff = in_count;
    if ((in_count == '0) || (in_count > nbytes_c)) begin
      count_eff = nbytes_c;
    end
  end

  always_comb begin
    byte_sel = 8'h00;
    for (int k = 0; k < nbytes; k++) begin
      if (index_inc == cntw'(k)) begin
        byte_sel = word_q[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_next = state;
    word_next  = word_q;
    index_next = index_q;
    count_next = count_q;
    data_next  = data_q;
    last_next  = last_q;
    if (accept) begin
      state_next = SEND;
      word_next  = in_data;
      index_next = '0;
      count_next = count_eff;
      data_next  = in_data[7:0];
      last_next  = (count_eff == one_c);
    end else if (transfer) begin
      if (last_q) begin
        state_next = IDLE;
        index_next = '0;
        count_next = '0;
        data_next  = 8'h00;
        last_next  = 1'b0;
      end else begin
        index_next = index_inc;
        data_next  = byte_sel;
        last_next  = (index_inc == (count_q - one_c));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      word_q  <= '0;
      index_q <= '0;
      count_q <= '0;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
    end else begin
      state   <= state_next;
      word_q  <= word_next;
      index_q <= index_next;
      count_q <= count_next;
      data_q  <= data_next;
      last_q  <= last_next;
    end
  end

endmodule

// File: tb/tb_word_unpacker.sv
// Testbench for word_unpacker: directed scenarios followed by random traffic,
// all checked against a byte-queue model of the expected output stream.
module tb_word_unpacker;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_count;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;

  int total;
  int bad;
  logic [8:0] exp_q[$];
  logic       after_reset;

  word_unpacker #(.width(32), .cntw(4)) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_count(in_count),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, expv, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the queue model, then
  // advance the model to what the coming edge should produce.
  task automatic applyStimulus(input logic rst, input logic iv, input logic [31:0] data,
                               input logic [3:0] cnt, input logic ordy);
    logic exp_ready;
    logic exp_valid;
    int   n;
    @(negedge clock);
    reset     = rst;
    in_valid  = iv;
    in_data   = data;
    in_count  = cnt;
    out_ready = ordy;
    #1;
    exp_valid = (exp_q.size() != 0);
    exp_ready = !rst && ((exp_q.size() == 0) || ((exp_q.size() == 1) && ordy));
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    checkOutput("busy", {31'd0, busy}, {31'd0, exp_valid});
    if (exp_valid) begin
      checkOutput("out_data", {24'd0, out_data}, {24'd0, exp_q[0][7:0]});
      checkOutput("out_last", {31'd0, out_last}, {31'd0, exp_q[0][8]});
    end
    if (after_reset) begin
      checkOutput("reset_out_data", {24'd0, out_data}, 32'd0);
      checkOutput("reset_out_last", {31'd0, out_last}, 32'd0);
    end
    after_reset = rst;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (exp_valid && ordy) begin
        void'(exp_q.pop_front());
      end
      if (iv && exp_ready) begin
        n = ((cnt == 0) || (cnt > 4)) ? 4 : int'(cnt);
        for (int k = 0; k < n; k++) begin
          exp_q.push_back({(k == n - 1), data[8*k +: 8]});
        end
      end
    end
  endtask

  task automatic idleCycles(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 4'd0, 1'b1);
    end
  endtask

  initial begin
    logic [6:0] bp_pattern;
    total       = 0;
    bad         = 0;
    after_reset = 1'b0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = 32'h0;
    in_count    = 4'd0;
    out_ready   = 1'b0;

    applyStimulus(1'b1, 1'b0, 32'h0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 4'd0, 1'b0);
    idleCycles(2);

    $display("[TB] full word");
    applyStimulus(1'b0, 1'b1, 32'hDDCCBBAA, 4'd0, 1'b1);
    idleCycles(6);

    $display("[TB] partial word and out-of-range count");
    applyStimulus(1'b0, 1'b1, 32'h44332211, 4'd2, 1'b1);
    idleCycles(4);
    applyStimulus(1'b0, 1'b1, 32'h88776655, 4'd7, 1'b1);
    idleCycles(6);

    $display("[TB] backpressure");
    applyStimulus(1'b0, 1'b1, 32'hDDCCBBAA, 4'd0, 1'b1);
    bp_pattern = 7'b1011001;
    for (int i = 6; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 4'd0, bp_pattern[i]);
    end
    idleCycles(3);

    $display("[TB] back-to-back");
    applyStimulus(1'b0, 1'b1, 32'h04030201, 4'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h000000F0, 4'd1, 1'b1);
    end
    idleCycles(4);

    $display("[TB] reset mid-word");
    applyStimulus(1'b0, 1'b1, 32'hDDCCBBAA, 4'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 4'd0, 1'b1);
    idleCycles(2);
    applyStimulus(1'b0, 1'b1, 32'h00000055, 4'd1, 1'b1);
    idleCycles(4);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 1) == 1),
                    $urandom,
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 9) < 7));
    end
    idleCycles(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
